// File: rtl/apb_initiator.sv
// APB4 initiator: accepts one request at a time on a valid/ready channel, runs the APB
// setup/access transfer with a bounded wait-state timeout, and returns the response.
module apb_initiator #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                req_write,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_strb,
   input  logic [2:0]          req_prot,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                out_psel,
   output logic                out_penable,
   output logic                out_pwrite,
   output logic [ADDR_W-1:0]   out_paddr,
   output logic [DATA_W-1:0]   out_pwdata,
   output logic [DATA_W/8-1:0] out_pstrb,
   output logic [2:0]          out_pprot,
   input  logic                out_pready,
   input  logic [DATA_W-1:0]   out_prdata,
   input  logic                out_pslverr
);
   localparam int STRB_W = DATA_W / 8;
   localparam bit TO_EN  = (TIMEOUT != 0);
   localparam int CNT_W  = TO_EN ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : CNT_ZERO;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic                accept_s;
   logic                capture_s;
   logic                abort_s;
   logic                ready_r;
   logic [CNT_W-1:0]    wait_cnt_r;
   logic [ADDR_W-1:0]   paddr_r;
   logic                pwrite_r;
   logic [DATA_W-1:0]   pwdata_r;
   logic [STRB_W-1:0]   pstrb_r;
   logic [2:0]          pprot_r;
   logic [DATA_W-1:0]   rdata_r;
   logic                err_r;

   // State register; reset drops psel/penable/rsp_valid without waiting for a clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and per-cycle strobes for accept, capture and timeout abort.
   always_comb begin
      state_s   = state_r;
      accept_s  = 1'b0;
      capture_s = 1'b0;
      abort_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid && ready_r) begin
               accept_s = 1'b1;
               state_s  = ST_SETUP;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_s = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (out_pready) begin
               capture_s = 1'b1;
               state_s   = ST_RESP;
            end else if (TO_EN && (wait_cnt_r == CNT_LAST)) begin
               abort_s = 1'b1;
               state_s = ST_RESP;
            end else begin
               state_s = ST_ACCESS;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // req_ready is held low through reset and rises on the first edge after release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ready_r <= 1'b0;
      end else begin
         ready_r <= (state_s == ST_IDLE);
      end
   end

   // Wait-state counter: cleared on acceptance, saturating, idle when the timeout is disabled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt_r <= CNT_ZERO;
      end else if (accept_s) begin
         wait_cnt_r <= CNT_ZERO;
      end else if (TO_EN && (state_r == ST_ACCESS) && !out_pready && (wait_cnt_r != CNT_MAX)) begin
         wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Request latch; read strobes are zeroed here so pstrb needs no decode downstream.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         paddr_r  <= {ADDR_W{1'b0}};
         pwrite_r <= 1'b0;
         pwdata_r <= {DATA_W{1'b0}};
         pstrb_r  <= {STRB_W{1'b0}};
         pprot_r  <= 3'b000;
      end else if (accept_s) begin
         paddr_r  <= req_addr;
         pwrite_r <= req_write;
         pwdata_r <= req_wdata;
         pstrb_r  <= req_write ? req_strb : {STRB_W{1'b0}};
         pprot_r  <= req_prot;
      end else begin
         paddr_r  <= paddr_r;
         pwrite_r <= pwrite_r;
         pwdata_r <= pwdata_r;
         pstrb_r  <= pstrb_r;
         pprot_r  <= pprot_r;
      end
   end

   // Response capture; pslverr data is passed through unmasked, timeouts return zero data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata_r <= {DATA_W{1'b0}};
         err_r   <= 1'b0;
      end else if (capture_s) begin
         rdata_r <= pwrite_r ? {DATA_W{1'b0}} : out_prdata;
         err_r   <= out_pslverr;
      end else if (abort_s) begin
         rdata_r <= {DATA_W{1'b0}};
         err_r   <= 1'b1;
      end else begin
         rdata_r <= rdata_r;
         err_r   <= err_r;
      end
   end

   assign req_ready   = ready_r;
   assign rsp_valid   = (state_r == ST_RESP);
   assign rsp_rdata   = rdata_r;
   assign rsp_err     = err_r;
   assign out_psel    = (state_r == ST_SETUP) || (state_r == ST_ACCESS);
   assign out_penable = (state_r == ST_ACCESS);
   assign out_pwrite  = pwrite_r;
   assign out_paddr   = paddr_r;
   assign out_pwdata  = pwdata_r;
   assign out_pstrb   = pstrb_r;
   assign out_pprot   = pprot_r;

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: directed and randomized transfers against a
// transaction-level expectation (latency, access cycles, data, error), plus a TIMEOUT=0 instance.
module tb_apb_initiator;
   localparam int TO_MAIN = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_write, rsp_ready, out_pready, out_pslverr;
   logic [31:0] req_addr, req_wdata, out_prdata;
   logic [3:0]  req_strb;
   logic [2:0]  req_prot;
   logic        req_ready, rsp_valid, rsp_err, out_psel, out_penable, out_pwrite;
   logic [31:0] rsp_rdata, out_paddr, out_pwdata;
   logic [3:0]  out_pstrb;
   logic [2:0]  out_pprot;

   logic        req0_valid, rsp0_ready, pready0;
   logic        req0_ready, rsp0_valid, rsp0_err, psel0, penable0, pwrite0;
   logic [31:0] rsp0_rdata, paddr0, pwdata0;
   logic [3:0]  pstrb0;
   logic [2:0]  pprot0;

   int passes = 0;
   int fails = 0;
   int total = 0;
   int cycle_cnt = 0;
   int prev_accept = 0;
   int cur_accept = 0;
   int n_rsp = 0;

   apb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO_MAIN)) u_dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
      .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
      .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb), .out_pprot(out_pprot),
      .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
   );

   apb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut0 (
      .clock(clock), .reset(reset),
      .req_valid(req0_valid), .req_ready(req0_ready), .req_addr(req_addr), .req_write(req_write),
      .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
      .rsp_valid(rsp0_valid), .rsp_ready(rsp0_ready), .rsp_rdata(rsp0_rdata), .rsp_err(rsp0_err),
      .out_psel(psel0), .out_penable(penable0), .out_pwrite(pwrite0),
      .out_paddr(paddr0), .out_pwdata(pwdata0), .out_pstrb(pstrb0), .out_pprot(pprot0),
      .out_pready(pready0), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full transfer from the requester's view; called at a negedge with the DUT idle.
   task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input logic [31:0] pd, input logic se, input int bp);
      logic        timed_out, got, exp_err;
      int          acc_exp, cyc, acc, bad;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_strb;
      timed_out = (waits >= TO_MAIN);
      acc_exp   = timed_out ? TO_MAIN : waits + 1;
      exp_rdata = (wr || timed_out) ? 32'h0 : pd;
      exp_err   = timed_out ? 1'b1 : se;
      exp_strb  = wr ? strb : 4'h0;
      chk("idle_ready", 32'(req_ready), 32'h1);
      cur_accept = cycle_cnt + 1;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_strb  = strb;
      req_prot  = prot;
      rsp_ready = 1'b0;
      got = 1'b0;
      cyc = 0;
      acc = 0;
      bad = 0;
      while (!got && cyc < 40) begin
         @(negedge clock);
         cyc++;
         req_valid   = 1'b0;
         req_addr    = $urandom;
         req_wdata   = $urandom;
         req_strb    = 4'($urandom);
         out_pready  = 1'($urandom_range(0, 1));
         out_prdata  = $urandom;
         out_pslverr = 1'($urandom_range(0, 1));
         if (cyc == 1) begin
            chk("setup_ctrl", 32'({out_psel, out_penable, out_pwrite, req_ready}),
                32'({1'b1, 1'b0, wr, 1'b0}));
            chk("setup_paddr", out_paddr, addr);
            chk("setup_pwdata", out_pwdata, wd);
            chk("setup_pstrb_pprot", 32'({out_pstrb, out_pprot}), 32'({exp_strb, prot}));
         end
         if (rsp_valid) begin
            got = 1'b1;
         end else if (out_psel && out_penable) begin
            if (out_paddr !== addr || out_pwrite !== wr || out_pwdata !== wd ||
                out_pstrb !== exp_strb || out_pprot !== prot) bad++;
            out_pready = (acc == waits);
            if (acc == waits) begin
               out_prdata  = pd;
               out_pslverr = se;
            end
            acc++;
         end
      end
      chk("rsp_seen", 32'(got), 32'h1);
      if (got) begin
         chk("latency", 32'(cyc), 32'(acc_exp + 2));
         chk("access_cycles", 32'(acc), 32'(acc_exp));
         chk("access_stable", 32'(bad), 32'h0);
         chk("rsp_rdata", rsp_rdata, exp_rdata);
         chk("rsp_ctrl", 32'({rsp_err, req_ready, out_psel, out_penable}), 32'({exp_err, 3'b000}));
         out_pready = 1'b0;
         for (int i = 0; i < bp; i++) begin
            @(negedge clock);
            chk("bp_rdata", rsp_rdata, exp_rdata);
            chk("bp_ctrl", 32'({rsp_valid, rsp_err, req_ready, out_psel}), 32'({1'b1, exp_err, 2'b00}));
         end
         rsp_ready = 1'b1;
         @(negedge clock);
         rsp_ready = 1'b0;
         chk("post_handshake", 32'({rsp_valid, req_ready, out_psel}), 32'(3'b010));
      end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      req_strb = 4'h0; req_prot = 3'b000; rsp_ready = 1'b0;
      out_pready = 1'b0; out_prdata = 32'h0; out_pslverr = 1'b0;
      req0_valid = 1'b0; rsp0_ready = 1'b0; pready0 = 1'b0;

      // Reset values
      @(negedge clock);
      chk("reset_ctrl", 32'({req_ready, rsp_valid, rsp_err, out_psel, out_penable, out_pwrite}), 32'h0);
      chk("reset_rdata", rsp_rdata, 32'h0);
      chk("reset_paddr", out_paddr, 32'h0);
      chk("reset_pwdata", out_pwdata, 32'h0);
      chk("reset_pstrb_pprot", 32'({out_pstrb, out_pprot}), 32'h0);
      @(negedge clock);
      reset = 1'b0;
      chk("ready_at_release", 32'(req_ready), 32'h0);
      @(negedge clock);
      chk("ready_after_release", 32'(req_ready), 32'h1);

      // Zero-wait write, 3-wait read, slave error, timeout, last-cycle completion
      txn(1'b1, 32'h1000_0004, 32'hA5A5_0001, 4'h1, 3'b000, 0, 32'h0, 1'b0, 0);
      txn(1'b0, 32'h1000_0000, 32'h1234_5678, 4'hF, 3'b010, 3, 32'hDEAD_BEEF, 1'b0, 0);
      txn(1'b0, 32'h1000_0008, 32'h0, 4'h0, 3'b001, 0, 32'h0000_00FF, 1'b1, 0);
      txn(1'b0, 32'h1000_000C, 32'h0, 4'h0, 3'b100, 1000, 32'hCAFE_F00D, 1'b0, 0);
      txn(1'b1, 32'h1000_0010, 32'h0BAD_CAFE, 4'hC, 3'b011, 1000, 32'h0, 1'b0, 0);
      txn(1'b0, 32'h1000_0014, 32'h0, 4'h0, 3'b000, TO_MAIN - 1, 32'h7777_1234, 1'b0, 0);

      // Response back-pressure, then back-to-back requests
      txn(1'b0, 32'h1000_0018, 32'h0, 4'h0, 3'b000, 1, 32'h5555_AAAA, 1'b1, 5);
      txn(1'b1, 32'h1000_001C, 32'h1111_2222, 4'h3, 3'b000, 0, 32'h0, 1'b0, 0);
      prev_accept = cur_accept;
      txn(1'b1, 32'h1000_0020, 32'h3333_4444, 4'h6, 3'b000, 0, 32'h0, 1'b0, 0);
      chk("throughput_4", 32'(cur_accept - prev_accept), 32'd4);

      // Randomized transfers; waits of TO_MAIN and above time out
      for (int n = 0; n < 24; n++) begin
         txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 3'($urandom),
             $urandom_range(0, 10), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      // Reset in the second ACCESS cycle of a waited read
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2000_0010; req_prot = 3'b000;
      out_pready = 1'b0;
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("pre_reset_access", 32'({out_psel, out_penable}), 32'(2'b11));
      #2 reset = 1'b1;
      #1 chk("async_reset_drop", 32'({out_psel, out_penable, rsp_valid, req_ready}), 32'h0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("ready_after_mid_reset", 32'(req_ready), 32'h1);
      n_rsp = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         out_pready = 1'($urandom_range(0, 1));
         if (rsp_valid || out_psel) n_rsp++;
      end
      out_pready = 1'b0;
      chk("no_rsp_after_reset", 32'(n_rsp), 32'h0);
      txn(1'b1, 32'h2000_0020, 32'hFEED_0042, 4'hF, 3'b010, 2, 32'h0, 1'b0, 0);

      // TIMEOUT=0 instance waits indefinitely
      req_write = 1'b0;
      req_addr  = 32'h3000_0000;
      chk("to0_ready", 32'(req0_ready), 32'h1);
      req0_valid = 1'b1;
      @(negedge clock);
      req0_valid = 1'b0;
      n_rsp = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         if (rsp0_valid) n_rsp++;
      end
      chk("to0_no_rsp", 32'(n_rsp), 32'h0);
      chk("to0_in_access", 32'({psel0, penable0}), 32'(2'b11));

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
